axi_rr_arbiter: RTL and testbench
=================================

# axi_rr_arbiter

Two-master to one-slave AXI4 arbiter with independent read and write arbitration. Each path grants one master at a time round-robin and holds the grant for a whole burst (address, all data beats, plus the write response). It sits between two AXI masters (e.g. DMA and CPU port) and a single AXI slave on the same channel set as the project AXI interface. It also counts beats against the granted LEN and flags protocol violations.

## Interface
- DATA_WIDTH, 1024: data bus width.
- ADDR_WIDTH, $clog2(32*DATA_WIDTH): address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sN_ARADDR/ARBURST/ARLEN/ARSIZE/ARVALID  in  ADDR_WIDTH/2/8/3/1  read address from master N (N = 0,1).
- sN_ARREADY  out  1  read address ready to master N.
- sN_RDATA/RRESP/RLAST/RVALID  out  DATA_WIDTH/2/1/1  read data to master N.
- sN_RREADY  in  1  read data ready from master N.
- sN_AWADDR/AWBURST/AWLEN/AWSIZE/AWVALID  in  ADDR_WIDTH/2/8/3/1  write address from master N.
- sN_AWREADY  out  1.
- sN_WDATA/WLAST/WVALID  in  DATA_WIDTH/1/1  write data from master N.
- sN_WREADY  out  1.
- sN_BRESP/BVALID  out  2/1  write response to master N.
- sN_BREADY  in  1.
- m_AR*, m_AW*, m_W*  out  same widths  to slave.
- m_R*, m_B*  in  same widths  from slave.
- m_ARREADY, m_AWREADY, m_WREADY  in  1.
- m_RREADY, m_BREADY  out  1.
- rd_err  out  1  one-cycle pulse, read beat-count mismatch.
- wr_err  out  1  one-cycle pulse, write beat-count mismatch.

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any sN_ARVALID, latch grant rgnt. Pick the master not last served when both request; a lone requester wins. Go to R_ADDR.
  - R_ADDR: m_AR* = granted sN_AR*; granted sN_ARREADY = m_ARREADY. On m_ARVALID&&m_ARREADY, load rcnt = ARLEN and go to R_DATA.
  - R_DATA: m_R* routed to the granted master; m_RREADY = granted sN_RREADY. Each R handshake decrements rcnt. An R handshake with RLAST goes to R_IDLE and sets rlast_gnt = rgnt.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE / W_ADDR: same as read, using AW signals. The AW handshake loads wcnt = AWLEN.
  - W_DATA: granted W forwarded to the slave. A W handshake with WLAST goes to W_RESP.
  - W_RESP: B routed to the granted master. A B handshake goes to W_IDLE and updates wlast_gnt.
- Non-granted master, and all masters in IDLE: READY and VALID outputs are 0; RDATA/RRESP/RLAST/BRESP are 0.
- W data presented before its grant stalls (WREADY=0). It is not buffered.
- Beat check, read: rd_err pulses when RLAST is handshaked with rcnt≠0, or when a beat handshakes with rcnt==0 and RLAST=0. Write uses the same rule with WLAST and wcnt. The FSM still follows xLAST.
- rcnt/wcnt are 8-bit and only decrement while nonzero; no wrap.
- Read and write paths are fully independent. Both may be granted to different masters or to the same master simultaneously.

## Timing
- Reset values: all FSMs IDLE; rlast_gnt = wlast_gnt = 1 (master 0 preferred first); every VALID/READY output, m_AR*/m_AW*/m_W* payload, rd_err and wr_err are 0.
- Arbitration latency: sN_xVALID seen in IDLE in cycle t gives m_xVALID high in cycle t+1. All routing is combinational from registered grant/state; there is no data-path register.
- Minimum turnaround after a completed burst: 1 IDLE cycle before the next grant.
- Grant never changes between the address handshake and the final LAST/B handshake.
- Async rst mid-burst: FSMs go to IDLE immediately, outputs drop to 0 within the cycle, counters clear.
- rd_err/wr_err are registered: asserted the cycle after the offending handshake.

## Test plan
- Both masters assert ARVALID together, ARLEN=3, after reset: master 0 is granted first with 4 R beats, RLAST on beat 4. Then master 1 is granted and m_ARADDR = s1_ARADDR one cycle after the IDLE cycle.
- Master 0 only, requesting back-to-back reads ARLEN=0: granted every burst, with one IDLE cycle between bursts.
- Write from master 1, AWLEN=7, with slave WREADY toggling: 8 W beats reach the slave in order; B goes only to master 1; s0_BVALID stays 0 throughout.
- Read burst ARLEN=3 but slave asserts RLAST on beat 2: FSM returns to IDLE and rd_err pulses for 1 cycle.
- Concurrent read by master 0 and write by master 1: both proceed with no stall between the paths.
- Assert rst during W_DATA beat 3 of 8: m_WVALID and s1_WREADY drop to 0 at once. After reset, the first request from master 0 is granted.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter: independent round-robin read and write paths,
// each holding its grant for a whole burst and flagging beat-count mismatches.
module axi_rr_arbiter #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = $clog2(32*DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s0_ARADDR,  input  logic [ADDR_WIDTH-1:0] s1_ARADDR,
  input  logic [1:0]            s0_ARBURST, input  logic [1:0]            s1_ARBURST,
  input  logic [7:0]            s0_ARLEN,   input  logic [7:0]            s1_ARLEN,
  input  logic [2:0]            s0_ARSIZE,  input  logic [2:0]            s1_ARSIZE,
  input  logic                  s0_ARVALID, input  logic                  s1_ARVALID,
  output logic                  s0_ARREADY, output logic                  s1_ARREADY,
  output logic [DATA_WIDTH-1:0] s0_RDATA,   output logic [DATA_WIDTH-1:0] s1_RDATA,
  output logic [1:0]            s0_RRESP,   output logic [1:0]            s1_RRESP,
  output logic                  s0_RLAST,   output logic                  s1_RLAST,
  output logic                  s0_RVALID,  output logic                  s1_RVALID,
  input  logic                  s0_RREADY,  input  logic                  s1_RREADY,
  input  logic [ADDR_WIDTH-1:0] s0_AWADDR,  input  logic [ADDR_WIDTH-1:0] s1_AWADDR,
  input  logic [1:0]            s0_AWBURST, input  logic [1:0]            s1_AWBURST,
  input  logic [7:0]            s0_AWLEN,   input  logic [7:0]            s1_AWLEN,
  input  logic [2:0]            s0_AWSIZE,  input  logic [2:0]            s1_AWSIZE,
  input  logic                  s0_AWVALID, input  logic                  s1_AWVALID,
  output logic                  s0_AWREADY, output logic                  s1_AWREADY,
  input  logic [DATA_WIDTH-1:0] s0_WDATA,   input  logic [DATA_WIDTH-1:0] s1_WDATA,
  input  logic                  s0_WLAST,   input  logic                  s1_WLAST,
  input  logic                  s0_WVALID,  input  logic                  s1_WVALID,
  output logic                  s0_WREADY,  output logic                  s1_WREADY,
  output logic [1:0]            s0_BRESP,   output logic [1:0]            s1_BRESP,
  output logic                  s0_BVALID,  output logic                  s1_BVALID,
  input  logic                  s0_BREADY,  input  logic                  s1_BREADY,
  output logic [ADDR_WIDTH-1:0] m_ARADDR,
  output logic [1:0]            m_ARBURST,
  output logic [7:0]            m_ARLEN,
  output logic [2:0]            m_ARSIZE,
  output logic                  m_ARVALID,
  input  logic                  m_ARREADY,
  input  logic [DATA_WIDTH-1:0] m_RDATA,
  input  logic [1:0]            m_RRESP,
  input  logic                  m_RLAST,
  input  logic                  m_RVALID,
  output logic                  m_RREADY,
  output logic [ADDR_WIDTH-1:0] m_AWADDR,
  output logic [1:0]            m_AWBURST,
  output logic [7:0]            m_AWLEN,
  output logic [2:0]            m_AWSIZE,
  output logic                  m_AWVALID,
  input  logic                  m_AWREADY,
  output logic [DATA_WIDTH-1:0] m_WDATA,
  output logic                  m_WLAST,
  output logic                  m_WVALID,
  input  logic                  m_WREADY,
  input  logic [1:0]            m_BRESP,
  input  logic                  m_BVALID,
  output logic                  m_BREADY,
  output logic                  rd_err,
  output logic                  wr_err
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t   r_state, r_next;
  w_state_t   w_state, w_next;
  logic       rgnt, rgnt_next, rlast_gnt;
  logic       wgnt, wgnt_next, wlast_gnt;
  logic [7:0] rcnt, wcnt;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs, wlast_sel;

  assign ar_hs     = (r_state == R_ADDR) && (rgnt ? s1_ARVALID : s0_ARVALID) && m_ARREADY;
  assign r_hs      = (r_state == R_DATA) && m_RVALID && (rgnt ? s1_RREADY : s0_RREADY);
  assign aw_hs     = (w_state == W_ADDR) && (wgnt ? s1_AWVALID : s0_AWVALID) && m_AWREADY;
  assign w_hs      = (w_state == W_DATA) && (wgnt ? s1_WVALID : s0_WVALID) && m_WREADY;
  assign b_hs      = (w_state == W_RESP) && m_BVALID && (wgnt ? s1_BREADY : s0_BREADY);
  assign wlast_sel = wgnt ? s1_WLAST : s0_WLAST;

  // Read path: next state, grant choice and routing from the registered grant.
  always_comb begin
    r_next = r_state;  rgnt_next = rgnt;
    m_ARADDR = '0;  m_ARBURST = 2'd0;  m_ARLEN = 8'd0;  m_ARSIZE = 3'd0;  m_ARVALID = 1'b0;
    s0_ARREADY = 1'b0;  s1_ARREADY = 1'b0;  m_RREADY = 1'b0;
    s0_RDATA = '0;  s0_RRESP = 2'd0;  s0_RLAST = 1'b0;  s0_RVALID = 1'b0;
    s1_RDATA = '0;  s1_RRESP = 2'd0;  s1_RLAST = 1'b0;  s1_RVALID = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s0_ARVALID || s1_ARVALID) begin
          r_next    = R_ADDR;
          rgnt_next = (s0_ARVALID && s1_ARVALID) ? ~rlast_gnt : s1_ARVALID;
        end else begin
          r_next = R_IDLE;
        end
      end
      R_ADDR: begin
        if (rgnt) begin
          m_ARADDR = s1_ARADDR;  m_ARBURST = s1_ARBURST;  m_ARLEN = s1_ARLEN;
          m_ARSIZE = s1_ARSIZE;  m_ARVALID = s1_ARVALID;  s1_ARREADY = m_ARREADY;
        end else begin
          m_ARADDR = s0_ARADDR;  m_ARBURST = s0_ARBURST;  m_ARLEN = s0_ARLEN;
          m_ARSIZE = s0_ARSIZE;  m_ARVALID = s0_ARVALID;  s0_ARREADY = m_ARREADY;
        end
        r_next = ar_hs ? R_DATA : R_ADDR;
      end
      R_DATA: begin
        if (rgnt) begin
          s1_RDATA = m_RDATA;  s1_RRESP = m_RRESP;  s1_RLAST = m_RLAST;
          s1_RVALID = m_RVALID;  m_RREADY = s1_RREADY;
        end else begin
          s0_RDATA = m_RDATA;  s0_RRESP = m_RRESP;  s0_RLAST = m_RLAST;
          s0_RVALID = m_RVALID;  m_RREADY = s0_RREADY;
        end
        r_next = (r_hs && m_RLAST) ? R_IDLE : R_DATA;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read path registers: state, grant history, beat counter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;  rgnt <= 1'b0;  rlast_gnt <= 1'b1;  rcnt <= 8'd0;  rd_err <= 1'b0;
    end else begin
      r_state <= r_next;
      rgnt    <= rgnt_next;
      rd_err  <= r_hs && (m_RLAST ? (rcnt != 8'd0) : (rcnt == 8'd0));
      if (ar_hs) rcnt <= m_ARLEN;
      else if (r_hs && rcnt != 8'd0) rcnt <= rcnt - 8'd1;
      if (r_hs && m_RLAST) rlast_gnt <= rgnt;
    end
  end

  // Write path: next state, grant choice and routing; W is only accepted once granted.
  always_comb begin
    w_next = w_state;  wgnt_next = wgnt;
    m_AWADDR = '0;  m_AWBURST = 2'd0;  m_AWLEN = 8'd0;  m_AWSIZE = 3'd0;  m_AWVALID = 1'b0;
    s0_AWREADY = 1'b0;  s1_AWREADY = 1'b0;
    m_WDATA = '0;  m_WLAST = 1'b0;  m_WVALID = 1'b0;  s0_WREADY = 1'b0;  s1_WREADY = 1'b0;
    s0_BRESP = 2'd0;  s0_BVALID = 1'b0;  s1_BRESP = 2'd0;  s1_BVALID = 1'b0;  m_BREADY = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s0_AWVALID || s1_AWVALID) begin
          w_next    = W_ADDR;
          wgnt_next = (s0_AWVALID && s1_AWVALID) ? ~wlast_gnt : s1_AWVALID;
        end else begin
          w_next = W_IDLE;
        end
      end
      W_ADDR: begin
        if (wgnt) begin
          m_AWADDR = s1_AWADDR;  m_AWBURST = s1_AWBURST;  m_AWLEN = s1_AWLEN;
          m_AWSIZE = s1_AWSIZE;  m_AWVALID = s1_AWVALID;  s1_AWREADY = m_AWREADY;
        end else begin
          m_AWADDR = s0_AWADDR;  m_AWBURST = s0_AWBURST;  m_AWLEN = s0_AWLEN;
          m_AWSIZE = s0_AWSIZE;  m_AWVALID = s0_AWVALID;  s0_AWREADY = m_AWREADY;
        end
        w_next = aw_hs ? W_DATA : W_ADDR;
      end
      W_DATA: begin
        if (wgnt) begin
          m_WDATA = s1_WDATA;  m_WLAST = s1_WLAST;  m_WVALID = s1_WVALID;  s1_WREADY = m_WREADY;
        end else begin
          m_WDATA = s0_WDATA;  m_WLAST = s0_WLAST;  m_WVALID = s0_WVALID;  s0_WREADY = m_WREADY;
        end
        w_next = (w_hs && wlast_sel) ? W_RESP : W_DATA;
      end
      W_RESP: begin
        if (wgnt) begin
          s1_BRESP = m_BRESP;  s1_BVALID = m_BVALID;  m_BREADY = s1_BREADY;
        end else begin
          s0_BRESP = m_BRESP;  s0_BVALID = m_BVALID;  m_BREADY = s0_BREADY;
        end
        w_next = b_hs ? W_IDLE : W_RESP;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write path registers: state, grant history, beat counter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;  wgnt <= 1'b0;  wlast_gnt <= 1'b1;  wcnt <= 8'd0;  wr_err <= 1'b0;
    end else begin
      w_state <= w_next;
      wgnt    <= wgnt_next;
      wr_err  <= w_hs && (wlast_sel ? (wcnt != 8'd0) : (wcnt == 8'd0));
      if (aw_hs) wcnt <= m_AWLEN;
      else if (w_hs && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
      if (b_hs) wlast_gnt <= wgnt;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter: arbitration order, burst holding,
// beat-count errors, concurrent paths and asynchronous reset mid-burst.
module tb_axi_rr_arbiter;
  localparam int DW = 32;
  localparam int AW = $clog2(32*DW);

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] s0_ARADDR, s1_ARADDR, s0_AWADDR, s1_AWADDR, m_ARADDR, m_AWADDR;
  logic [1:0] s0_ARBURST, s1_ARBURST, s0_AWBURST, s1_AWBURST, m_ARBURST, m_AWBURST;
  logic [7:0] s0_ARLEN, s1_ARLEN, s0_AWLEN, s1_AWLEN, m_ARLEN, m_AWLEN;
  logic [2:0] s0_ARSIZE, s1_ARSIZE, s0_AWSIZE, s1_AWSIZE, m_ARSIZE, m_AWSIZE;
  logic s0_ARVALID, s1_ARVALID, s0_ARREADY, s1_ARREADY, m_ARVALID, m_ARREADY;
  logic s0_AWVALID, s1_AWVALID, s0_AWREADY, s1_AWREADY, m_AWVALID, m_AWREADY;
  logic [DW-1:0] s0_RDATA, s1_RDATA, m_RDATA, s0_WDATA, s1_WDATA, m_WDATA;
  logic [1:0] s0_RRESP, s1_RRESP, m_RRESP, s0_BRESP, s1_BRESP, m_BRESP;
  logic s0_RLAST, s1_RLAST, m_RLAST, s0_RVALID, s1_RVALID, m_RVALID;
  logic s0_RREADY, s1_RREADY, m_RREADY;
  logic s0_WLAST, s1_WLAST, m_WLAST, s0_WVALID, s1_WVALID, m_WVALID;
  logic s0_WREADY, s1_WREADY, m_WREADY;
  logic s0_BVALID, s1_BVALID, m_BVALID, s0_BREADY, s1_BREADY, m_BREADY;
  logic rd_err, wr_err;

  int vectors = 0;
  int miscompares = 0;

  axi_rr_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_ARADDR(s0_ARADDR), .s1_ARADDR(s1_ARADDR), .s0_ARBURST(s0_ARBURST), .s1_ARBURST(s1_ARBURST),
    .s0_ARLEN(s0_ARLEN), .s1_ARLEN(s1_ARLEN), .s0_ARSIZE(s0_ARSIZE), .s1_ARSIZE(s1_ARSIZE),
    .s0_ARVALID(s0_ARVALID), .s1_ARVALID(s1_ARVALID), .s0_ARREADY(s0_ARREADY), .s1_ARREADY(s1_ARREADY),
    .s0_RDATA(s0_RDATA), .s1_RDATA(s1_RDATA), .s0_RRESP(s0_RRESP), .s1_RRESP(s1_RRESP),
    .s0_RLAST(s0_RLAST), .s1_RLAST(s1_RLAST), .s0_RVALID(s0_RVALID), .s1_RVALID(s1_RVALID),
    .s0_RREADY(s0_RREADY), .s1_RREADY(s1_RREADY),
    .s0_AWADDR(s0_AWADDR), .s1_AWADDR(s1_AWADDR), .s0_AWBURST(s0_AWBURST), .s1_AWBURST(s1_AWBURST),
    .s0_AWLEN(s0_AWLEN), .s1_AWLEN(s1_AWLEN), .s0_AWSIZE(s0_AWSIZE), .s1_AWSIZE(s1_AWSIZE),
    .s0_AWVALID(s0_AWVALID), .s1_AWVALID(s1_AWVALID), .s0_AWREADY(s0_AWREADY), .s1_AWREADY(s1_AWREADY),
    .s0_WDATA(s0_WDATA), .s1_WDATA(s1_WDATA), .s0_WLAST(s0_WLAST), .s1_WLAST(s1_WLAST),
    .s0_WVALID(s0_WVALID), .s1_WVALID(s1_WVALID), .s0_WREADY(s0_WREADY), .s1_WREADY(s1_WREADY),
    .s0_BRESP(s0_BRESP), .s1_BRESP(s1_BRESP), .s0_BVALID(s0_BVALID), .s1_BVALID(s1_BVALID),
    .s0_BREADY(s0_BREADY), .s1_BREADY(s1_BREADY),
    .m_ARADDR(m_ARADDR), .m_ARBURST(m_ARBURST), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
    .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .m_AWADDR(m_AWADDR), .m_AWBURST(m_AWBURST), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int cyc;
    logic exp_wr;
    {s0_ARADDR, s1_ARADDR, s0_ARBURST, s1_ARBURST, s0_ARLEN, s1_ARLEN, s0_ARSIZE, s1_ARSIZE} = '0;
    {s0_ARVALID, s1_ARVALID, s0_RREADY, s1_RREADY, m_ARREADY} = '0;
    {m_RDATA, m_RRESP, m_RLAST, m_RVALID} = '0;
    {s0_AWADDR, s1_AWADDR, s0_AWBURST, s1_AWBURST, s0_AWLEN, s1_AWLEN, s0_AWSIZE, s1_AWSIZE} = '0;
    {s0_AWVALID, s1_AWVALID, m_AWREADY} = '0;
    {s0_WDATA, s1_WDATA, s0_WLAST, s1_WLAST, s0_WVALID, s1_WVALID, m_WREADY} = '0;
    {m_BRESP, m_BVALID, s0_BREADY, s1_BREADY} = '0;

    // Reset state
    step(); step();
    check("rst_arvalid", m_ARVALID, 1'b0);
    check("rst_awvalid", m_AWVALID, 1'b0);
    check("rst_wvalid", m_WVALID, 1'b0);
    check("rst_araddr", m_ARADDR, 0);
    check("rst_errs", {rd_err, wr_err}, 2'b00);
    rst = 1'b0;
    step();

    // Both masters request reads, ARLEN=3: master 0 first, then master 1
    s0_ARVALID = 1'b1; s0_ARADDR = 10'h011; s0_ARLEN = 8'd3;
    s1_ARVALID = 1'b1; s1_ARADDR = 10'h022; s1_ARLEN = 8'd3;
    #1 check("t1_idle_arvalid", m_ARVALID, 1'b0);
    step();
    check("t1_arvalid", m_ARVALID, 1'b1);
    check("t1_araddr0", m_ARADDR, 10'h011);
    check("t1_arlen", m_ARLEN, 8'd3);
    m_ARREADY = 1'b1;
    #1 check("t1_arready", {s0_ARREADY, s1_ARREADY}, 2'b10);
    step();
    s0_ARVALID = 1'b0; m_ARREADY = 1'b0; s0_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_RVALID = 1'b1; m_RDATA = 32'h100 + i; m_RLAST = (i == 3);
      #1;
      check("t1_r0_valid", {s0_RVALID, s1_RVALID, m_RREADY}, 3'b101);
      check("t1_r0_data", s0_RDATA, 32'h100 + i);
      check("t1_r0_last", s0_RLAST, (i == 3));
      step();
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0;
    #1 check("t1_rd_err", rd_err, 1'b0);
    check("t1_turnaround", m_ARVALID, 1'b0);
    m_ARREADY = 1'b1;
    step();
    check("t1_araddr1", m_ARADDR, 10'h022);
    check("t1_arready1", {m_ARVALID, s0_ARREADY, s1_ARREADY}, 3'b101);
    step();
    s1_ARVALID = 1'b0; m_ARREADY = 1'b0; s0_RREADY = 1'b0; s1_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_RVALID = 1'b1; m_RDATA = 32'h300 + i; m_RLAST = (i == 3);
      #1;
      check("t1_r1_valid", {s0_RVALID, s1_RVALID, m_RREADY}, 3'b011);
      check("t1_r1_data", s1_RDATA, 32'h300 + i);
      step();
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0; s1_RREADY = 1'b0;

    // Back-to-back single-beat reads from master 0
    s0_ARVALID = 1'b1; s0_ARLEN = 8'd0; m_ARREADY = 1'b1;
    m_RVALID = 1'b1; m_RLAST = 1'b1; s0_RREADY = 1'b1;
    for (int b = 0; b < 2; b++) begin
      s0_ARADDR = 10'h040 + b;
      #1 check("t2_idle", {m_ARVALID, s0_RVALID}, 2'b00);
      step();
      check("t2_addr", {m_ARVALID, s0_ARREADY, s0_RVALID}, 3'b110);
      check("t2_araddr", m_ARADDR, 10'h040 + b);
      step();
      if (b == 1) s0_ARVALID = 1'b0;
      #1 check("t2_data", s0_RVALID, 1'b1);
      step();
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0; s0_RREADY = 1'b0; m_ARREADY = 1'b0;
    check("t2_rd_err", rd_err, 1'b0);

    // Write from master 1, AWLEN=7, toggling WREADY; early W must stall
    s1_AWVALID = 1'b1; s1_AWADDR = 10'h033; s1_AWLEN = 8'd7;
    step();
    s1_WVALID = 1'b1; s1_WDATA = 32'h200; m_WREADY = 1'b1; m_AWREADY = 1'b1;
    #1 check("t3_aw", {m_AWVALID, s0_AWREADY, s1_AWREADY}, 3'b101);
    check("t3_awaddr", m_AWADDR, 10'h033);
    check("t3_early_w", {m_WVALID, s1_WREADY}, 2'b00);
    step();
    s1_AWVALID = 1'b0; m_AWREADY = 1'b0;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 24) begin
      exp_wr = (cyc % 2 == 1);
      m_WREADY = exp_wr; s1_WDATA = 32'h200 + k; s1_WLAST = (k == 7);
      #1;
      check("t3_wvalid", {m_WVALID, s1_WREADY, s0_WREADY, s0_BVALID}, {1'b1, exp_wr, 2'b00});
      check("t3_wdata", m_WDATA, 32'h200 + k);
      check("t3_wlast", m_WLAST, (k == 7));
      if (exp_wr) k++;
      cyc++;
      step();
    end
    check("t3_beats", k, 8);
    s1_WVALID = 1'b0; s1_WLAST = 1'b0; m_WREADY = 1'b0;
    check("t3_wr_err", wr_err, 1'b0);
    m_BVALID = 1'b1; m_BRESP = 2'b10; s1_BREADY = 1'b1;
    #1 check("t3_b", {s0_BVALID, s1_BVALID, m_BREADY}, 3'b011);
    check("t3_bresp", {s0_BRESP, s1_BRESP}, 4'b0010);
    step();
    m_BVALID = 1'b0; m_BRESP = 2'b00; s1_BREADY = 1'b0;
    #1 check("t3_b_done", {s0_BVALID, s1_BVALID}, 2'b00);

    // Short burst: ARLEN=3 with RLAST on beat 2
    s0_ARVALID = 1'b1; s0_ARLEN = 8'd3; m_ARREADY = 1'b1;
    step(); step();
    s0_ARVALID = 1'b0; m_ARREADY = 1'b0;
    m_RVALID = 1'b1; m_RLAST = 1'b0; s0_RREADY = 1'b1;
    #1 check("t4_no_err", rd_err, 1'b0);
    step();
    m_RLAST = 1'b1;
    step();
    check("t4_rd_err", rd_err, 1'b1);
    check("t4_idle", s0_RVALID, 1'b0);
    step();
    check("t4_pulse", rd_err, 1'b0);
    m_RVALID = 1'b0; m_RLAST = 1'b0; s0_RREADY = 1'b0;

    // Concurrent read (master 0) and write (master 1), 2 beats each
    s0_ARVALID = 1'b1; s0_ARLEN = 8'd1; s1_AWVALID = 1'b1; s1_AWLEN = 8'd1;
    m_ARREADY = 1'b1; m_AWREADY = 1'b1;
    step();
    check("t5_addr", {m_ARVALID, m_AWVALID, s0_ARREADY, s1_AWREADY}, 4'b1111);
    step();
    s0_ARVALID = 1'b0; s1_AWVALID = 1'b0; m_ARREADY = 1'b0; m_AWREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_RVALID = 1'b1; m_RLAST = (i == 1); s0_RREADY = 1'b1;
      s1_WVALID = 1'b1; s1_WLAST = (i == 1); s1_WDATA = 32'h500 + i; m_WREADY = 1'b1;
      #1 check("t5_beat", {s0_RVALID, m_WVALID, s1_WREADY}, 3'b111);
      check("t5_wdata", m_WDATA, 32'h500 + i);
      step();
    end
    m_RVALID = 1'b0; m_RLAST = 1'b0; s1_WVALID = 1'b0; s1_WLAST = 1'b0; m_WREADY = 1'b0;
    m_BVALID = 1'b1; s1_BREADY = 1'b1;
    #1 check("t5_b", {s1_BVALID, s0_BVALID}, 2'b10);
    check("t5_errs", {rd_err, wr_err}, 2'b00);
    step();
    m_BVALID = 1'b0; s1_BREADY = 1'b0;

    // Async reset during W beat 3 of 8 from master 1
    s1_AWVALID = 1'b1; s1_AWLEN = 8'd7; m_AWREADY = 1'b1;
    step(); step();
    s1_AWVALID = 1'b0; m_AWREADY = 1'b0; s1_WVALID = 1'b1; m_WREADY = 1'b1;
    step(); step();
    #1 check("t6_beat3", {m_WVALID, s1_WREADY}, 2'b11);
    rst = 1'b1;
    #1 check("t6_rst_drop", {m_WVALID, s1_WREADY}, 2'b00);
    step();
    rst = 1'b0; s1_WVALID = 1'b0; m_WREADY = 1'b0;
    s0_AWVALID = 1'b1; s0_AWADDR = 10'h0A0; s1_AWVALID = 1'b1; s1_AWADDR = 10'h0B0;
    m_AWREADY = 1'b1;
    #1 check("t6_idle", m_AWVALID, 1'b0);
    step();
    check("t6_grant0", m_AWADDR, 10'h0A0);
    check("t6_ready0", {s0_AWREADY, s1_AWREADY}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
